// File: rtl/param_stack_if.sv
// rtl/param_stack_if.sv - push/pop request and status bundle for param_stack
interface param_stack_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 6
);
  logic                  push;
  logic                  pop;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic [PTR_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;
  logic                  error;

  modport master (
    output push, pop, clear_err, data_in,
    input  data_out, full, empty, count, overflow, underflow, error
  );

  modport slave (
    input  push, pop, clear_err, data_in,
    output data_out, full, empty, count, overflow, underflow, error
  );
endinterface

// File: rtl/param_stack.sv
// rtl/param_stack.sv - parametrised LIFO with edge qualification, replace-top and sticky errors
module param_stack #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int PTR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int EDGE_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  param_stack_if.slave         bus,
  output logic [PTR_WIDTH-1:0] debug_ptr_reg,
  output logic [PTR_WIDTH-1:0] debug_ptr_next,
  output logic                 debug_push_q,
  output logic                 debug_pop_q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PTR_WIDTH-1:0] ONE      = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] FULL_CNT = PTR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  ptr, ptr_next, ptr_m1;
  logic [AW-1:0]         wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] dout, dout_next;
  logic                  push_d1, pop_d1, push_q, pop_q;
  logic                  full, empty, we, ovf_set, udf_set;
  logic                  ovf_r, udf_r;

  always_comb begin
    push_q = bus.push;
    pop_q  = bus.pop;
    if (EDGE_MODE != 0) begin
      push_q = bus.push & ~push_d1;
      pop_q  = bus.pop & ~pop_d1;
    end
  end

  always_comb begin
    full     = (ptr == FULL_CNT);
    empty    = (ptr == '0);
    ptr_m1   = ptr - ONE;
    ptr_next = ptr;
    we       = 1'b0;
    wr_idx   = AW'(ptr);
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    unique case ({push_q, pop_q})
      2'b10: begin
        if (full) ovf_set = 1'b1;
        else begin
          we       = 1'b1;
          ptr_next = ptr + ONE;
        end
      end
      2'b01: begin
        if (empty) udf_set = 1'b1;
        else ptr_next = ptr_m1;
      end
      2'b11: begin
        // replace overwrites the current top; on an empty stack it degenerates to a push
        we = 1'b1;
        if (empty) ptr_next = ptr + ONE;
        else wr_idx = AW'(ptr_m1);
      end
      default: ;
    endcase
    rd_idx = AW'(ptr_next - ONE);
    // a write always lands on the new top, so forward data_in instead of reading stale memory
    if (ptr_next == '0) dout_next = '0;
    else if (we)        dout_next = bus.data_in;
    else                dout_next = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr     <= '0;
      dout    <= '0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
      push_d1 <= 1'b0;
      pop_d1  <= 1'b0;
    end else begin
      ptr     <= ptr_next;
      dout    <= dout_next;
      ovf_r   <= ovf_set | (ovf_r & ~bus.clear_err);
      udf_r   <= udf_set | (udf_r & ~bus.clear_err);
      push_d1 <= bus.push;
      pop_d1  <= bus.pop;
    end
  end

  always_ff @(posedge clk) begin
    if (we && reset) mem[wr_idx] <= bus.data_in;
  end

  assign bus.data_out    = dout;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = ptr;
  assign bus.overflow    = ovf_r;
  assign bus.underflow   = udf_r;
  assign bus.error       = ovf_r | udf_r;
  assign debug_ptr_reg   = ptr;
  assign debug_ptr_next  = ptr_next;
  assign debug_push_q    = push_q;
  assign debug_pop_q     = pop_q;
endmodule

// File: tb/tb_param_stack.sv
// tb/tb_param_stack.sv - edge-mode and level-mode stacks checked against an array model
module tb_param_stack;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [7:0] din = 8'h00;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  param_stack_if #(.DATA_WIDTH(8), .PTR_WIDTH(6)) bus_e ();
  param_stack_if #(.DATA_WIDTH(8), .PTR_WIDTH(4)) bus_l ();

  assign bus_e.push = push;  assign bus_e.pop = pop;
  assign bus_e.clear_err = clr;  assign bus_e.data_in = din;
  assign bus_l.push = push;  assign bus_l.pop = pop;
  assign bus_l.clear_err = clr;  assign bus_l.data_in = din;

  logic [5:0] e_dpr, e_dpn;
  logic       e_dpq, e_doq;
  logic [3:0] l_dpr, l_dpn;
  logic       l_dpq, l_doq;

  param_stack #(.DATA_WIDTH(8), .DEPTH(32), .EDGE_MODE(1)) u_edge (
    .clk(clk), .reset(rst), .bus(bus_e.slave),
    .debug_ptr_reg(e_dpr), .debug_ptr_next(e_dpn),
    .debug_push_q(e_dpq), .debug_pop_q(e_doq));

  param_stack #(.DATA_WIDTH(8), .DEPTH(8), .EDGE_MODE(0)) u_level (
    .clk(clk), .reset(rst), .bus(bus_l.slave),
    .debug_ptr_reg(l_dpr), .debug_ptr_next(l_dpn),
    .debug_push_q(l_dpq), .debug_pop_q(l_doq));

  // index 0 = edge-mode DUT (depth 32), index 1 = level-mode DUT (depth 8)
  logic [7:0] m_stk [2][32];
  int         m_cnt [2];
  bit         m_ovf [2], m_udf [2], m_pp [2], m_po [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int id, input int depth, input bit edge_mode);
    bit pq, oq, oset, uset;
    if (!rst) begin
      m_cnt[id] = 0; m_ovf[id] = 0; m_udf[id] = 0; m_pp[id] = 0; m_po[id] = 0;
      return;
    end
    pq = edge_mode ? (push && !m_pp[id]) : push;
    oq = edge_mode ? (pop && !m_po[id]) : pop;
    m_pp[id] = push; m_po[id] = pop;
    oset = 0; uset = 0;
    if (pq && (!oq || m_cnt[id] == 0)) begin
      if (m_cnt[id] == depth) oset = 1;
      else begin m_stk[id][m_cnt[id]] = din; m_cnt[id]++; end
    end else if (pq && oq) begin
      m_stk[id][m_cnt[id]-1] = din;
    end else if (oq) begin
      if (m_cnt[id] == 0) uset = 1;
      else m_cnt[id]--;
    end
    m_ovf[id] = oset || (m_ovf[id] && !clr);
    m_udf[id] = uset || (m_udf[id] && !clr);
  endtask

  task automatic tick();
    logic [7:0] top;
    @(posedge clk);
    model(0, 32, 1'b1);
    model(1, 8, 1'b0);
    #1;
    top = (m_cnt[0] == 0) ? 8'h00 : m_stk[0][m_cnt[0]-1];
    chk("e_count", 32'(bus_e.count), 32'(m_cnt[0]));
    chk("e_dout", 32'(bus_e.data_out), 32'(top));
    chk("e_full", 32'(bus_e.full), 32'(m_cnt[0] == 32));
    chk("e_empty", 32'(bus_e.empty), 32'(m_cnt[0] == 0));
    chk("e_ovf", 32'(bus_e.overflow), 32'(m_ovf[0]));
    chk("e_udf", 32'(bus_e.underflow), 32'(m_udf[0]));
    chk("e_err", 32'(bus_e.error), 32'(m_ovf[0] | m_udf[0]));
    top = (m_cnt[1] == 0) ? 8'h00 : m_stk[1][m_cnt[1]-1];
    chk("l_count", 32'(bus_l.count), 32'(m_cnt[1]));
    chk("l_dout", 32'(bus_l.data_out), 32'(top));
    chk("l_full", 32'(bus_l.full), 32'(m_cnt[1] == 8));
    chk("l_empty", 32'(bus_l.empty), 32'(m_cnt[1] == 0));
    chk("l_ovf", 32'(bus_l.overflow), 32'(m_ovf[1]));
    chk("l_udf", 32'(bus_l.underflow), 32'(m_udf[1]));
  endtask

  initial begin
    // reset held with push high
    rst = 1'b0; push = 1'b1;
    repeat (3) tick();
    chk("rst_count", 32'(bus_e.count), 32'd0);
    chk("rst_err", 32'(bus_e.error), 32'd0);
    push = 1'b0; rst = 1'b1;
    tick();

    // fill with 0x00..0x1F, then one rejected push
    for (int i = 0; i < 32; i++) begin
      din = 8'(i); push = 1'b1; tick();
      push = 1'b0; tick();
    end
    chk("fill_full", 32'(bus_e.full), 32'd1);
    chk("fill_top", 32'(bus_e.data_out), 32'h1f);
    din = 8'hAA; push = 1'b1; tick();
    push = 1'b0; tick();
    chk("ovf_count", 32'(bus_e.count), 32'd32);

    // drain plus one rejected pop, then clear the flags
    for (int i = 0; i < 33; i++) begin
      pop = 1'b1; tick();
      pop = 1'b0; tick();
    end
    chk("udf_flag", 32'(bus_e.underflow), 32'd1);
    clr = 1'b1; tick();
    clr = 1'b0; tick();
    chk("clr_err", 32'(bus_e.error), 32'd0);

    // replace-top
    din = 8'h11; push = 1'b1; tick(); push = 1'b0; tick();
    din = 8'h22; push = 1'b1; tick(); push = 1'b0; tick();
    din = 8'h33; push = 1'b1; pop = 1'b1; tick();
    push = 1'b0; pop = 1'b0; tick();
    chk("repl_top", 32'(bus_e.data_out), 32'h33);
    pop = 1'b1; tick(); pop = 1'b0; tick();
    chk("repl_pop", 32'(bus_e.data_out), 32'h11);

    // level vs edge: push held high
    din = 8'h5A; push = 1'b1;
    repeat (5) tick();
    push = 1'b0; tick();

    // randomized traffic with occasional resets and clears
    for (int i = 0; i < 600; i++) begin
      push = ($urandom_range(0, 99) < 45);
      pop  = ($urandom_range(0, 99) < 40);
      clr  = ($urandom_range(0, 99) < 5);
      rst  = ($urandom_range(0, 99) >= 2);
      din  = 8'($urandom);
      tick();
    end
    push = 1'b0; pop = 1'b0; clr = 1'b0;

    // reset on the same edge as a push at count 7
    rst = 1'b0; tick(); rst = 1'b1; tick();
    for (int i = 0; i < 7; i++) begin
      din = 8'(8'h40 + i); push = 1'b1; tick();
      push = 1'b0; tick();
    end
    chk("pre_rst_count", 32'(bus_e.count), 32'd7);
    din = 8'hEE; push = 1'b1; rst = 1'b0; tick();
    chk("midop_count", 32'(bus_e.count), 32'd0);
    chk("midop_dout", 32'(bus_e.data_out), 32'd0);
    push = 1'b0; rst = 1'b1; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack. Successor to the fixed 8-bit/32-entry stack.
- Adds configurable width and depth, optional rising-edge qualification of push/pop, and a replace-top operation when push and pop occur together.
- Adds full/empty/count status, and separate sticky overflow/underflow flags with a clear input.
- Sits behind the switch debouncers in board tops; its debug outputs feed the ILA.

Parameters:
- DATA_WIDTH, 8: width of each stack entry.
- DEPTH, 32: number of entries; must be a power of two, 2..1024.
- PTR_WIDTH, $clog2(DEPTH)+1: pointer/count width; holds 0..DEPTH inclusive.
- EDGE_MODE, 1: 1 = push/pop act on the rising edge of the input only; 0 = act on every cycle the input is high.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- push  in  1  push request.
- pop  in  1  pop request.
- clear_err  in  1  clears the sticky error flags.
- data_in  in  DATA_WIDTH  value to push.
- data_out  out  DATA_WIDTH  registered top-of-stack.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  PTR_WIDTH  current number of entries.
- overflow  out  1  sticky: a push was rejected because the stack was full.
- underflow  out  1  sticky: a pop was rejected because the stack was empty.
- error  out  1  overflow | underflow.
- debug_ptr_reg  out  PTR_WIDTH  registered pointer.
- debug_ptr_next  out  PTR_WIDTH  combinational next pointer.
- debug_push_q  out  1  qualified push strobe.
- debug_pop_q  out  1  qualified pop strobe.

Behaviour:
- Reset (reset==0 at a clk edge):
  - ptr=0, data_out=0, empty=1, full=0, count=0, overflow=0, underflow=0.
  - Edge-detect history registers = 0.
  - Memory contents are not cleared.
  - Reset has priority over all other inputs, including mid-operation; an op presented on the same edge is discarded.
- Qualification:
  - EDGE_MODE=1: push_q = push & ~push_d1, where push_d1 is push registered; pop likewise.
  - EDGE_MODE=0: push_q = push, pop_q = pop.
- Operations, decoded from {push_q, pop_q}; each takes effect on one clk edge:
  - 00 idle: no change.
  - 10 push:
    - If not full: mem[ptr]=data_in, ptr+1.
    - If full: no write, ptr unchanged, overflow set.
  - 01 pop:
    - If not empty: ptr-1.
    - If empty: ptr unchanged, underflow set.
  - 11 replace:
    - If not empty: mem[ptr-1]=data_in, ptr unchanged; no flag, even when full.
    - If empty: behaves as push.
- count = ptr. full and empty are derived from the registered ptr and valid in the same cycle as count.
- data_out:
  - Registered; one cycle after the op edge it equals the new top (mem[new_ptr-1]).
  - It is 0 whenever the new ptr is 0.
  - After a push or replace it equals the pushed data_in, with no read-before-write hazard.
- Error flags:
  - overflow and underflow stay set until clear_err=1 or reset.
  - If clear_err and a new error occur on the same edge, the flag is set (the new error wins).
- Pointer never wraps; rejected ops leave memory and ptr untouched.
- Memory is inferred as distributed or block RAM with synchronous write.

Test Plan:
- Reset: hold reset=0 for 3 cycles with push=1 -> count=0, empty=1, data_out=0, error=0.
- Fill (EDGE_MODE=1, DEPTH=32): 32 push edges with data 0x00..0x1F -> full=1, count=32, data_out=0x1F. A 33rd push with 0xAA -> overflow=1, count=32, data_out=0x1F.
- Drain: from full, 32 pop edges -> data_out steps 0x1E..0x00 then 0, empty=1. A further pop -> underflow=1, count=0. Pulse clear_err -> error=0 next cycle.
- Replace: push 0x11, push 0x22, then push and pop rising together with data_in=0x33 -> count=2, data_out=0x33. A pop -> data_out=0x11.
- Level mode (EDGE_MODE=0): hold push high 5 cycles with data 0x5A -> count=5. Hold push high 3 cycles with EDGE_MODE=1 -> count increments by 1 only.
- Reset mid-op: assert reset on the same edge as a push at count=7 -> count=0, no write visible, flags clear.
